wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: single-cycle ALU results and a buffered slow path
// share one write port, with starvation protection for the buffered entries.
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_rd,
    input  logic [31:0]              mem_data,
    output logic                     regwrite,
    output logic [4:0]               write_register,
    output logic [31:0]              write_data,
    output logic                     alu_stall,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [4:0]    rdMem   [DEPTH];
    logic [31:0]   dataMem [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [SW-1:0] starveCnt_q, starveCnt_d;
    logic          stall_q, stall_d;
    logic          err_q, err_d;
    logic          regwrite_q, regwrite_d;
    logic [4:0]    wreg_q, wreg_d;
    logic [31:0]   wdata_q, wdata_d;

    logic push, pop, aluReq, aluWin, dropAlu;

    // Occupancy at cycle start gates both acceptance and popping, so a fresh
    // entry in an empty buffer is only poppable from the following cycle on.
    always_comb begin
        push    = mem_valid && mem_ready && (mem_rd != 5'd0);
        aluReq  = alu_valid && (alu_rd != 5'd0);
        aluWin  = aluReq && !stall_q;
        pop     = (count_q != '0) && !aluWin;
        dropAlu = aluReq && stall_q;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + 1'b1 : rdPtr_q;

        starveCnt_d = starveCnt_q;
        if (pop || (count_q == '0)) begin
            starveCnt_d = '0;
        end else if (starveCnt_q != LIMIT_C) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end

        if (stall_q) begin
            stall_d = !pop;
        end else begin
            stall_d = !pop && (count_q != '0) && (starveCnt_d == LIMIT_C);
        end

        err_d = err_q | dropAlu;
    end

    // Losing cycles leave the write address/data untouched.
    always_comb begin
        regwrite_d = aluWin || pop;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (aluWin) begin
            wreg_d  = alu_rd;
            wdata_d = alu_data;
        end else if (pop) begin
            wreg_d  = rdMem[rdPtr_q];
            wdata_d = dataMem[rdPtr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            starveCnt_q <= '0;
            stall_q     <= 1'b0;
            err_q       <= 1'b0;
            regwrite_q  <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
        end else begin
            count_q     <= count_d;
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            starveCnt_q <= starveCnt_d;
            stall_q     <= stall_d;
            err_q       <= err_d;
            regwrite_q  <= regwrite_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rdMem[wrPtr_q]   <= mem_rd;
            dataMem[wrPtr_q] <= mem_data;
        end
    end

    assign mem_ready      = (count_q < DEPTH_C);
    assign count          = count_q;
    assign regwrite       = regwrite_q;
    assign write_register = wreg_q;
    assign write_data     = wdata_q;
    assign alu_stall      = stall_q;
    assign err_drop       = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes are queued as stimulus is
// driven and matched in order against every regwrite pulse.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        regwrite;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        alu_stall;
    logic [2:0]  count;
    logic        err_drop;

    int checks = 0;
    int errors = 0;
    logic [36:0] expQ[$];

    wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .regwrite(regwrite), .write_register(write_register), .write_data(write_data),
        .alu_stall(alu_stall), .count(count), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic av, input int ard, input int adata,
                         input logic mv, input int mrd, input int mdata);
        alu_valid = av;
        alu_rd    = 5'(ard);
        alu_data  = 32'(adata);
        mem_valid = mv;
        mem_rd    = 5'(mrd);
        mem_data  = 32'(mdata);
    endtask

    // Every write the DUT issues is matched against the head of the expected queue.
    task automatic stepCycle();
        logic [36:0] exp;
        @(posedge clk);
        #1;
        if (regwrite === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL write_unexpected: got rd=%0d data=%h, expected no write", write_register, write_data);
            end else begin
                exp = expQ.pop_front();
                if ({write_register, write_data} !== exp) begin
                    errors++;
                    $display("[TB] FAIL write_value: got rd=%0d data=%h, expected rd=%0d data=%h",
                             write_register, write_data, exp[36:32], exp[31:0]);
                end
            end
        end else if (regwrite !== 1'b0) begin
            checks++;
            errors++;
            $display("[TB] FAIL regwrite_x: got %b, expected 0 or 1", regwrite);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (regwrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_regwrite: got %b expected 0", regwrite); end
        checks++; if (write_register !== 5'd0) begin errors++; $display("[TB] FAIL reset_wreg: got %0d expected 0", write_register); end
        checks++; if (write_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", write_data); end
        checks++; if (alu_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", alu_stall); end
        checks++; if (err_drop !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err_drop); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", mem_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_alu_single();
        drive(1, 5, 32'h1234, 0, 0, 0);
        expQ.push_back({5'd5, 32'h1234});
        stepCycle();
        checks++; if (regwrite !== 1'b1) begin errors++; $display("[TB] FAIL alu_latency: got regwrite=%b expected 1", regwrite); end
        drive(0, 0, 0, 0, 0, 0);
        stepCycle();
        checks++; if (regwrite !== 1'b0) begin errors++; $display("[TB] FAIL alu_idle: got regwrite=%b expected 0", regwrite); end
        checks++; if ({write_register, write_data} !== {5'd5, 32'h1234}) begin
            errors++; $display("[TB] FAIL alu_hold: got rd=%0d data=%h expected rd=5 data=1234", write_register, write_data);
        end
        drive(1, 0, 32'hDEAD, 0, 0, 0);
        stepCycle();
        checks++; if (regwrite !== 1'b0) begin errors++; $display("[TB] FAIL alu_rd0: got regwrite=%b expected 0", regwrite); end
        drive(0, 0, 0, 0, 0, 0);
        stepCycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            drive(1, i, i * 32'h111, 0, 0, 0);
            expQ.push_back({5'(i), 32'(i * 32'h111)});
            stepCycle();
        end
        drive(0, 0, 0, 0, 0, 0);
        stepCycle();
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL b2b_missing: got %0d pending expected 0", expQ.size()); end
    endtask

    task automatic test_mem_latency();
        drive(0, 0, 0, 1, 7, 32'hAA);
        stepCycle();
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL mem_count1: got %0d expected 1", count); end
        checks++; if (regwrite !== 1'b0) begin errors++; $display("[TB] FAIL mem_early: got regwrite=%b expected 0", regwrite); end
        drive(0, 0, 0, 0, 0, 0);
        expQ.push_back({5'd7, 32'hAA});
        stepCycle();
        checks++; if (regwrite !== 1'b1) begin errors++; $display("[TB] FAIL mem_latency: got regwrite=%b expected 1", regwrite); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL mem_count0: got %0d expected 0", count); end
        drive(0, 0, 0, 1, 0, 32'hBB);
        stepCycle();
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL mem_rd0: got count %0d expected 0", count); end
        drive(0, 0, 0, 0, 0, 0);
        stepCycle();
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL mem_missing: got %0d pending expected 0", expQ.size()); end
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < 4; i++) begin
            drive(1, 10 + i, 32'hA0 + i, 1, 1 + i, 32'hB0 + i);
            expQ.push_back({5'(10 + i), 32'(32'hA0 + i)});
            stepCycle();
            if (i == 2) begin
                checks++; if (alu_stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_early: got %b expected 0", alu_stall); end
            end
        end
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL full_count: got %0d expected 4", count); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b expected 0", mem_ready); end
        checks++; if (alu_stall !== 1'b1) begin errors++; $display("[TB] FAIL stall_rise: got %b expected 1", alu_stall); end
        drive(1, 20, 32'hDEAD, 1, 5, 32'hB5);
        expQ.push_back({5'd1, 32'hB0});
        stepCycle();
        checks++; if (err_drop !== 1'b1) begin errors++; $display("[TB] FAIL drop_flag: got %b expected 1", err_drop); end
        checks++; if (alu_stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_clear: got %b expected 0", alu_stall); end
        checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL full_pop: got count %0d expected 3", count); end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 4; i++) expQ.push_back({5'(1 + i), 32'(32'hB0 + i)});
        repeat (4) stepCycle();
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL full_drain: got count %0d expected 0", count); end
        checks++; if (err_drop !== 1'b1) begin errors++; $display("[TB] FAIL drop_sticky: got %b expected 1", err_drop); end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL full_missing: got %0d pending expected 0", expQ.size()); end
    endtask

    task automatic test_push_pop();
        drive(1, 11, 32'hC1, 1, 12, 32'hD1);
        expQ.push_back({5'd11, 32'hC1});
        stepCycle();
        drive(1, 13, 32'hC2, 1, 14, 32'hD2);
        expQ.push_back({5'd13, 32'hC2});
        stepCycle();
        checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL pp_pre: got count %0d expected 2", count); end
        drive(0, 0, 0, 1, 15, 32'hD3);
        expQ.push_back({5'd12, 32'hD1});
        stepCycle();
        checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL pp_same: got count %0d expected 2", count); end
        drive(0, 0, 0, 0, 0, 0);
        expQ.push_back({5'd14, 32'hD2});
        expQ.push_back({5'd15, 32'hD3});
        repeat (3) stepCycle();
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL pp_missing: got %0d pending expected 0", expQ.size()); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 0, 1, 16 + i, 32'hE0 + i);
            expQ.push_back({5'(16 + i), 32'(32'hE0 + i)});
            stepCycle();
        end
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 1", count); end
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) stepCycle();
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL wrap_drain: got count %0d expected 0", count); end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL wrap_missing: got %0d pending expected 0", expQ.size()); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1, 25 + i, 32'hF0 + i, 1, 28 + i, 32'h70 + i);
            expQ.push_back({5'(25 + i), 32'(32'hF0 + i)});
            stepCycle();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 3", count); end
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL mid_rst_count: got %0d expected 0", count); end
        checks++; if (regwrite !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_we: got %b expected 0", regwrite); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_ready: got %b expected 1", mem_ready); end
        checks++; if (err_drop !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_err: got %b expected 0", err_drop); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) stepCycle();
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL mid_after: got count %0d expected 0", count); end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL mid_missing: got %0d pending expected 0", expQ.size()); end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_back_to_back();
        test_mem_latency();
        test_full_stall();
        test_push_pop();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
